// File: rtl/battle_engine_param.sv
// Parametrised turn-based melee engine: one handshaked move per side per turn.
// Optional macro BATTLE_ACCURACY_EN adds an LFSR-driven miss chance.
module battle_engine_param #(
  parameter int HP_W        = 8,
  parameter int MAX_HP      = 100,
  parameter int AMMO_W      = 5,
  parameter int SWORD_INIT  = 3,
  parameter int BAT_INIT    = 3,
  parameter int DMG_FIST    = 2,
  parameter int DMG_SWORD   = 10,
  parameter int DMG_BAT     = 6,
  parameter int HEAL_AMT    = 8,
  parameter int MISS_THRESH = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              collision_detected,
  input  logic [1:0]        player_choice,
  input  logic              player_valid,
  output logic              player_ready,
  input  logic [1:0]        enemy_choice,
  input  logic              enemy_valid,
  output logic              enemy_ready,
  output logic [HP_W-1:0]   player_HP,
  output logic [HP_W-1:0]   enemy_HP,
  output logic [AMMO_W-1:0] player_remained_sword,
  output logic [AMMO_W-1:0] player_remained_baseballbat,
  output logic [AMMO_W-1:0] enemy_remained_sword,
  output logic [AMMO_W-1:0] enemy_remained_baseballbat,
  output logic              last_miss,
  output logic              player_win,
  output logic              enemy_win
);

  typedef enum logic [2:0] {
    S_IDLE, S_P_TURN, S_P_APPLY, S_E_TURN, S_E_APPLY, S_DONE
  } state_t;

  typedef logic [HP_W-1:0]   hp_t;
  typedef logic [HP_W:0]     hpx_t;
  typedef logic [AMMO_W-1:0] ammo_t;

  localparam hp_t   HP_FULL = hp_t'(MAX_HP);
  localparam ammo_t SW_FULL = ammo_t'(SWORD_INIT);
  localparam ammo_t BT_FULL = ammo_t'(BAT_INIT);

  state_t     r_state, w_state_n;
  hp_t        r_php, r_ehp, w_php_n, w_ehp_n;
  ammo_t      r_psw, r_pbat, r_esw, r_ebat;
  ammo_t      w_psw_n, w_pbat_n, w_esw_n, w_ebat_n;
  logic [1:0] r_choice, w_choice_n;
  logic       r_ended, w_ended_n;
  logic       r_pwin, r_ewin, w_pwin_n, w_ewin_n;
  logic       r_miss, w_miss_n;
  logic       w_miss_roll;

`ifdef BATTLE_ACCURACY_EN
  logic [7:0] r_lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_lfsr <= 8'hA5;
    else        r_lfsr <= {r_lfsr[6:0],
                           r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end

  assign w_miss_roll = 32'(r_lfsr) < MISS_THRESH;
`else
  logic w_unused_thresh;
  assign w_unused_thresh = MISS_THRESH > 0;
  assign w_miss_roll     = 1'b0;
`endif

  // Shared attacker/defender datapath, steered by which side is applying
  logic  w_is_p, w_heal, w_attack, w_miss;
  ammo_t w_att_sw, w_att_bat, w_att_sw_n, w_att_bat_n;
  hp_t   w_att_hp, w_def_hp, w_att_hp_n, w_def_hp_n;
  hpx_t  w_dmg, w_sub, w_add;

  always_comb begin
    w_is_p      = r_state == S_P_APPLY;
    w_att_sw    = w_is_p ? r_psw  : r_esw;
    w_att_bat   = w_is_p ? r_pbat : r_ebat;
    w_att_hp    = w_is_p ? r_php  : r_ehp;
    w_def_hp    = w_is_p ? r_ehp  : r_php;
    w_att_sw_n  = w_att_sw;
    w_att_bat_n = w_att_bat;
    w_dmg       = hpx_t'(DMG_FIST);
    w_heal      = 1'b0;
    w_attack    = 1'b1;
    case (r_choice)
      2'b01: if (w_att_sw != '0) begin
        w_att_sw_n = w_att_sw - ammo_t'(1);
        w_dmg      = hpx_t'(DMG_SWORD);
      end
      2'b10: if (w_att_bat != '0) begin
        w_att_bat_n = w_att_bat - ammo_t'(1);
        w_dmg       = hpx_t'(DMG_BAT);
      end
      2'b11: begin
        w_heal   = 1'b1;
        w_attack = 1'b0;
        w_dmg    = '0;
      end
      default: ;
    endcase
    w_miss = w_attack & w_miss_roll;
    if (w_miss) w_dmg = '0;
    w_sub      = {1'b0, w_def_hp} - w_dmg;
    w_def_hp_n = w_sub[HP_W] ? '0 : w_sub[HP_W-1:0];
    w_add      = {1'b0, w_att_hp} + hpx_t'(HEAL_AMT);
    w_att_hp_n = w_att_hp;
    if (w_heal)
      w_att_hp_n = (w_add > hpx_t'(MAX_HP)) ? HP_FULL : w_add[HP_W-1:0];
  end

  always_comb begin
    w_state_n  = r_state;
    w_php_n    = r_php;
    w_ehp_n    = r_ehp;
    w_psw_n    = r_psw;
    w_pbat_n   = r_pbat;
    w_esw_n    = r_esw;
    w_ebat_n   = r_ebat;
    w_choice_n = r_choice;
    w_ended_n  = r_ended;
    w_pwin_n   = r_pwin;
    w_ewin_n   = r_ewin;
    w_miss_n   = 1'b0;
    case (r_state)
      S_IDLE: if (collision_detected) begin
        w_state_n = S_P_TURN;
        w_pwin_n  = 1'b0;
        w_ewin_n  = 1'b0;
        w_ended_n = 1'b0;
        if (r_ended) begin
          w_php_n  = HP_FULL;
          w_ehp_n  = HP_FULL;
          w_psw_n  = SW_FULL;
          w_pbat_n = BT_FULL;
          w_esw_n  = SW_FULL;
          w_ebat_n = BT_FULL;
        end
      end
      S_P_TURN: begin
        if (!collision_detected) w_state_n = S_IDLE;
        else if (player_valid) begin
          w_choice_n = player_choice;
          w_state_n  = S_P_APPLY;
        end
      end
      S_E_TURN: begin
        if (!collision_detected) w_state_n = S_IDLE;
        else if (enemy_valid) begin
          w_choice_n = enemy_choice;
          w_state_n  = S_E_APPLY;
        end
      end
      S_P_APPLY: begin
        w_psw_n  = w_att_sw_n;
        w_pbat_n = w_att_bat_n;
        w_php_n  = w_att_hp_n;
        w_ehp_n  = w_def_hp_n;
        w_miss_n = w_miss;
        if (w_def_hp_n == '0) begin
          w_state_n = S_DONE;
          w_pwin_n  = 1'b1;
          w_ended_n = 1'b1;
        end else w_state_n = S_E_TURN;
      end
      S_E_APPLY: begin
        w_esw_n  = w_att_sw_n;
        w_ebat_n = w_att_bat_n;
        w_ehp_n  = w_att_hp_n;
        w_php_n  = w_def_hp_n;
        w_miss_n = w_miss;
        if (w_def_hp_n == '0) begin
          w_state_n = S_DONE;
          w_ewin_n  = 1'b1;
          w_ended_n = 1'b1;
        end else w_state_n = S_P_TURN;
      end
      S_DONE: if (!collision_detected) w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_php    <= HP_FULL;
      r_ehp    <= HP_FULL;
      r_psw    <= SW_FULL;
      r_pbat   <= BT_FULL;
      r_esw    <= SW_FULL;
      r_ebat   <= BT_FULL;
      r_choice <= 2'b00;
      r_ended  <= 1'b0;
      r_pwin   <= 1'b0;
      r_ewin   <= 1'b0;
      r_miss   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_php    <= w_php_n;
      r_ehp    <= w_ehp_n;
      r_psw    <= w_psw_n;
      r_pbat   <= w_pbat_n;
      r_esw    <= w_esw_n;
      r_ebat   <= w_ebat_n;
      r_choice <= w_choice_n;
      r_ended  <= w_ended_n;
      r_pwin   <= w_pwin_n;
      r_ewin   <= w_ewin_n;
      r_miss   <= w_miss_n;
    end
  end

  assign player_ready                = r_state == S_P_TURN;
  assign enemy_ready                 = r_state == S_E_TURN;
  assign player_HP                   = r_php;
  assign enemy_HP                    = r_ehp;
  assign player_remained_sword       = r_psw;
  assign player_remained_baseballbat = r_pbat;
  assign enemy_remained_sword        = r_esw;
  assign enemy_remained_baseballbat  = r_ebat;
  assign last_miss                   = r_miss;
  assign player_win                  = r_pwin;
  assign enemy_win                   = r_ewin;

endmodule

// File: tb/tb_battle_engine_param.sv
// Bench for battle_engine_param: directed scenarios plus randomized battles
// checked against an arithmetic model of HP, ammo and turn order.
module tb_battle_engine_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       collision_detected = 1'b0;
  logic [1:0] player_choice = 2'b00, enemy_choice = 2'b00;
  logic       player_valid = 1'b0, enemy_valid = 1'b0;
  logic       player_ready, enemy_ready;
  logic [7:0] player_HP, enemy_HP;
  logic [4:0] p_sw, p_bat, e_sw, e_bat;
  logic       last_miss, player_win, enemy_win;

  logic       t_col = 1'b0;
  logic [1:0] t_pc = 2'b00, t_ec = 2'b00;
  logic       t_pv = 1'b0, t_ev = 1'b0;
  logic       t_pr, t_er, t_miss, t_pw, t_ew;
  logic [7:0] t_php, t_ehp;
  logic [4:0] t_psw, t_pbat, t_esw, t_ebat;

  int total = 0;
  int bad = 0;

  int m_hp[2];
  int m_sw[2];
  int m_bat[2];

  always #5 clk = ~clk;

  battle_engine_param dut (
    .clk(clk), .rst_n(rst_n),
    .collision_detected(collision_detected),
    .player_choice(player_choice), .player_valid(player_valid),
    .player_ready(player_ready),
    .enemy_choice(enemy_choice), .enemy_valid(enemy_valid),
    .enemy_ready(enemy_ready),
    .player_HP(player_HP), .enemy_HP(enemy_HP),
    .player_remained_sword(p_sw),
    .player_remained_baseballbat(p_bat),
    .enemy_remained_sword(e_sw),
    .enemy_remained_baseballbat(e_bat),
    .last_miss(last_miss),
    .player_win(player_win), .enemy_win(enemy_win)
  );

  battle_engine_param #(.MAX_HP(10)) dut10 (
    .clk(clk), .rst_n(rst_n),
    .collision_detected(t_col),
    .player_choice(t_pc), .player_valid(t_pv), .player_ready(t_pr),
    .enemy_choice(t_ec), .enemy_valid(t_ev), .enemy_ready(t_er),
    .player_HP(t_php), .enemy_HP(t_ehp),
    .player_remained_sword(t_psw),
    .player_remained_baseballbat(t_pbat),
    .enemy_remained_sword(t_esw),
    .enemy_remained_baseballbat(t_ebat),
    .last_miss(t_miss),
    .player_win(t_pw), .enemy_win(t_ew)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void m_init();
    for (int s = 0; s < 2; s++) begin
      m_hp[s] = 100;
      m_sw[s] = 3;
      m_bat[s] = 3;
    end
  endfunction

  // Rules: weapons degrade to fist when empty, heal caps at 100, HP floors at 0
  function automatic bit m_apply(int s, logic [1:0] c);
    int o = 1 - s;
    int d = 2;
    case (c)
      2'd1: if (m_sw[s] > 0) begin m_sw[s]--; d = 10; end
      2'd2: if (m_bat[s] > 0) begin m_bat[s]--; d = 6; end
      2'd3: begin
        d = 0;
        m_hp[s] = (m_hp[s] + 8 > 100) ? 100 : m_hp[s] + 8;
      end
      default: ;
    endcase
    m_hp[o] = (m_hp[o] - d < 0) ? 0 : m_hp[o] - d;
    return m_hp[o] == 0;
  endfunction

  function automatic logic [35:0] m_stats();
    return {8'(m_hp[0]), 8'(m_hp[1]), 5'(m_sw[0]), 5'(m_bat[0]),
            5'(m_sw[1]), 5'(m_bat[1])};
  endfunction

  function automatic logic [35:0] d_stats();
    return {player_HP, enemy_HP, p_sw, p_bat, e_sw, e_bat};
  endfunction

  task automatic move(input int s, input logic [1:0] c, output bit won);
    int n = 0;
    logic [1:0] exp_r, exp_w;
    while (((s == 0) ? player_ready : enemy_ready) !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    total++;
    if (((s == 0) ? player_ready : enemy_ready) !== 1'b1) begin
      $display("FAIL move_ready side=%0d got=%b want=1", s,
               (s == 0) ? player_ready : enemy_ready);
      bad++;
    end
    if (s == 0) begin player_choice = c; player_valid = 1'b1; end
    else        begin enemy_choice = c;  enemy_valid = 1'b1;  end
    step();
    player_valid = 1'b0;
    enemy_valid = 1'b0;
    player_choice = 2'($urandom_range(3, 0));
    enemy_choice = 2'($urandom_range(3, 0));
    step();
    won = m_apply(s, c);
    exp_w = won ? ((s == 0) ? 2'b10 : 2'b01) : 2'b00;
    exp_r = won ? 2'b00 : ((s == 0) ? 2'b01 : 2'b10);
    total++;
    if (d_stats() !== m_stats()) begin
      $display("FAIL move_stats side=%0d choice=%0d got=%h want=%h",
               s, c, d_stats(), m_stats());
      bad++;
    end
    total++;
    if ({player_win, enemy_win} !== exp_w) begin
      $display("FAIL move_win got=%b want=%b", {player_win, enemy_win}, exp_w);
      bad++;
    end
    total++;
    if ({player_ready, enemy_ready} !== exp_r) begin
      $display("FAIL move_ready_after got=%b want=%b",
               {player_ready, enemy_ready}, exp_r);
      bad++;
    end
    total++;
    if (last_miss !== 1'b0) begin
      $display("FAIL last_miss got=%b want=0", last_miss);
      bad++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    collision_detected = 1'b0;
    player_valid = 1'b0;
    enemy_valid = 1'b0;
    t_col = 1'b0;
    t_pv = 1'b0;
    t_ev = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    m_init();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (d_stats() !== {8'd100, 8'd100, 5'd3, 5'd3, 5'd3, 5'd3}) begin
      $display("FAIL reset_stats got=%h", d_stats());
      bad++;
    end
    total++;
    if ({player_ready, enemy_ready, player_win, enemy_win, last_miss} !== 5'b0)
    begin
      $display("FAIL reset_flags got=%b want=00000",
               {player_ready, enemy_ready, player_win, enemy_win, last_miss});
      bad++;
    end
  endtask

  task automatic test_first_turn();
    bit won;
    collision_detected = 1'b1;
    step();
    total++;
    if ({player_ready, enemy_ready} !== 2'b10) begin
      $display("FAIL p_turn_ready got=%b want=10", {player_ready, enemy_ready});
      bad++;
    end
    move(0, 2'd1, won);
    total++;
    if (enemy_HP !== 8'd90 || p_sw !== 5'd2) begin
      $display("FAIL sword_hit ehp=%0d psw=%0d want 90/2", enemy_HP, p_sw);
      bad++;
    end
    move(1, 2'd2, won);
    total++;
    if (player_HP !== 8'd94 || e_bat !== 5'd2) begin
      $display("FAIL bat_hit php=%0d ebat=%0d want 94/2", player_HP, e_bat);
      bad++;
    end
  endtask

  task automatic test_sword_exhaust();
    bit won;
    do_reset();
    collision_detected = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      move(0, 2'd1, won);
      move(1, 2'd0, won);
    end
    total++;
    if (enemy_HP !== 8'd68 || p_sw !== 5'd0 || player_HP !== 8'd92) begin
      $display("FAIL sword_exhaust ehp=%0d psw=%0d php=%0d want 68/0/92",
               enemy_HP, p_sw, player_HP);
      bad++;
    end
  endtask

  task automatic test_heal();
    bit won;
    do_reset();
    collision_detected = 1'b1;
    step();
    move(0, 2'd0, won);
    move(1, 2'd2, won);
    enemy_choice = 2'd1;
    enemy_valid = 1'b1;
    step();
    step();
    enemy_valid = 1'b0;
    total++;
    if ({player_ready, enemy_ready} !== 2'b10 || d_stats() !== m_stats()) begin
      $display("FAIL ignore_enemy ready=%b stats=%h want 10/%h",
               {player_ready, enemy_ready}, d_stats(), m_stats());
      bad++;
    end
    move(0, 2'd3, won);
    total++;
    if (player_HP !== 8'd100) begin
      $display("FAIL heal_cap php=%0d want=100", player_HP);
      bad++;
    end
  endtask

  task automatic test_pause();
    logic [35:0] snap;
    snap = m_stats();
    collision_detected = 1'b0;
    step();
    step();
    total++;
    if ({player_ready, enemy_ready} !== 2'b00 || d_stats() !== snap) begin
      $display("FAIL pause_idle ready=%b stats=%h want 00/%h",
               {player_ready, enemy_ready}, d_stats(), snap);
      bad++;
    end
    collision_detected = 1'b1;
    step();
    total++;
    if ({player_ready, enemy_ready} !== 2'b10 || d_stats() !== snap) begin
      $display("FAIL pause_resume ready=%b stats=%h want 10/%h",
               {player_ready, enemy_ready}, d_stats(), snap);
      bad++;
    end
  endtask

  task automatic test_reset_mid_apply();
    player_choice = 2'd1;
    player_valid = 1'b1;
    step();
    player_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    m_init();
    total++;
    if (d_stats() !== m_stats() ||
        {player_ready, enemy_ready, player_win, enemy_win} !== 4'b0) begin
      $display("FAIL async_reset stats=%h flags=%b want %h/0000", d_stats(),
               {player_ready, enemy_ready, player_win, enemy_win}, m_stats());
      bad++;
    end
    step();
    rst_n = 1'b1;
    collision_detected = 1'b0;
    step();
  endtask

  task automatic test_maxhp10();
    t_col = 1'b1;
    step();
    t_pc = 2'd1;
    t_pv = 1'b1;
    step();
    t_pv = 1'b0;
    step();
    step();
    step();
    total++;
    if (t_ehp !== 8'd0 || t_php !== 8'd10 || t_psw !== 5'd2) begin
      $display("FAIL clamp10 ehp=%0d php=%0d psw=%0d want 0/10/2",
               t_ehp, t_php, t_psw);
      bad++;
    end
    total++;
    if ({t_pw, t_ew, t_pr, t_er} !== 4'b1000) begin
      $display("FAIL done10 flags=%b want=1000", {t_pw, t_ew, t_pr, t_er});
      bad++;
    end
    t_col = 1'b0;
    step();
    total++;
    if (t_pw !== 1'b1) begin
      $display("FAIL win_held got=%b want=1", t_pw);
      bad++;
    end
    t_col = 1'b1;
    step();
    total++;
    if ({t_php, t_ehp, t_psw, t_pbat, t_esw, t_ebat} !==
        {8'd10, 8'd10, 5'd3, 5'd3, 5'd3, 5'd3} ||
        {t_pw, t_ew, t_pr} !== 3'b001) begin
      $display("FAIL reload10 stats=%h flags=%b",
               {t_php, t_ehp, t_psw, t_pbat, t_esw, t_ebat}, {t_pw, t_ew, t_pr});
      bad++;
    end
    t_col = 1'b0;
  endtask

  task automatic test_random();
    bit won;
    int turn = 0;
    logic [1:0] ew;
    do_reset();
    collision_detected = 1'b1;
    step();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7, 0) == 0) begin
        collision_detected = 1'b0;
        repeat ($urandom_range(3, 1)) step();
        collision_detected = 1'b1;
        step();
        turn = 0;
      end
      move(turn, 2'($urandom_range(3, 0)), won);
      if (won) begin
        ew = {player_win, enemy_win};
        step();
        step();
        total++;
        if ({player_ready, enemy_ready} !== 2'b00 ||
            {player_win, enemy_win} !== ew || d_stats() !== m_stats()) begin
          $display("FAIL done_hold ready=%b win=%b stats=%h",
                   {player_ready, enemy_ready}, {player_win, enemy_win},
                   d_stats());
          bad++;
        end
        collision_detected = 1'b0;
        step();
        collision_detected = 1'b1;
        step();
        m_init();
        total++;
        if (d_stats() !== m_stats() ||
            {player_win, enemy_win, player_ready} !== 3'b001) begin
          $display("FAIL reload stats=%h flags=%b want %h/001", d_stats(),
                   {player_win, enemy_win, player_ready}, m_stats());
          bad++;
        end
        turn = 0;
      end else begin
        turn = 1 - turn;
      end
    end
  endtask

  initial begin
    m_init();
    test_reset();
    test_first_turn();
    test_sword_exhaust();
    test_heal();
    test_pause();
    test_reset_mid_apply();
    test_maxhp10();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
